phase_diff_avg: RTL and testbench

PHASE_DIFF_AVG -- requirements
Module: phase_diff_avg

---
 rtl/phase_diff_avg.sv | 128 ++++++++++++
 tb/tb_phase_diff_avg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_diff_avg.sv
// Mean phase step estimator: averages 2^LOG2N wrapped phase differences per result.
// Each result is held on a valid/ready source port until the consumer takes it.
module phase_diff_avg #(
  parameter int LOG2N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic [15:0] sink_phase,
  input  logic        sink_clear,
  output logic        source_valid,
  input  logic        source_ready,
  output logic [15:0] source_freq
);

  localparam int ACC_W = 16 + LOG2N;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Difference of two Q3.13 phases, folded back into [-pi, pi]; +/-pi pass unchanged.
  function automatic logic [15:0] wrap_diff(input logic [15:0] cur, input logic [15:0] prev);
    logic signed [16:0] d;
    d = $signed({cur[15], cur}) - $signed({prev[15], prev});
    if (d > 17'sd25736) begin
      d = d - 17'sd51472;
    end else if (d < -17'sd25736) begin
      d = d + 17'sd51472;
    end else begin
      d = d;
    end
    return d[15:0];
  endfunction

  state_t                    state_r, state_s;
  logic [15:0]               ref_r, ref_s;
  logic signed [ACC_W-1:0]   acc_r, acc_s;
  logic [LOG2N-1:0]          cnt_r, cnt_s;
  logic                      valid_r, valid_s;
  logic [15:0]               freq_r, freq_s;
  logic                      accept_s;
  logic [15:0]               diff_s;
  logic signed [ACC_W-1:0]   acc_sum_s;

  assign sink_ready   = ~valid_r | source_ready;
  assign source_valid = valid_r;
  assign source_freq  = freq_r;
  assign accept_s     = sink_valid & sink_ready;
  assign diff_s       = wrap_diff(sink_phase, ref_r);
  assign acc_sum_s    = acc_r + $signed({{LOG2N{diff_s[15]}}, diff_s});

  // Next-state: clear/reference handling, accumulation and result load.
  always_comb begin
    state_s = state_r;
    ref_s   = ref_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    freq_s  = freq_r;
    if (valid_r && source_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end

    if (accept_s && sink_clear) begin
      // A clear with a coincident sample restarts with that sample as reference.
      state_s = RUN;
      ref_s   = sink_phase;
      acc_s   = '0;
      cnt_s   = '0;
    end else if (sink_clear) begin
      state_s = EMPTY;
      acc_s   = '0;
      cnt_s   = '0;
    end else if (accept_s) begin
      ref_s = sink_phase;
      case (state_r)
        EMPTY: begin
          state_s = RUN;
          acc_s   = '0;
          cnt_s   = '0;
        end
        RUN: begin
          if (cnt_r == {LOG2N{1'b1}}) begin
            // Floor division by N is the arithmetic-shift slice of the final sum.
            freq_s  = acc_sum_s[LOG2N+15:LOG2N];
            valid_s = 1'b1;
            acc_s   = '0;
            cnt_s   = '0;
          end else begin
            acc_s = acc_sum_s;
            cnt_s = cnt_r + LOG2N'(1);
          end
        end
        default: begin
          state_s = EMPTY;
          acc_s   = '0;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ref_r   <= 16'h0000;
      acc_r   <= '0;
      cnt_r   <= '0;
      valid_r <= 1'b0;
      freq_r  <= 16'h0000;
    end else begin
      state_r <= state_s;
      ref_r   <= ref_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      valid_r <= valid_s;
      freq_r  <= freq_s;
    end
  end

endmodule

// File: tb/tb_phase_diff_avg.sv
// Directed bench for phase_diff_avg with N = 4; expected values are hand-computed.
module tb_phase_diff_avg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sink_valid;
  logic        sink_ready;
  logic [15:0] sink_phase;
  logic        sink_clear;
  logic        source_valid;
  logic        source_ready;
  logic [15:0] source_freq;

  int vectors = 0;
  int miscompares = 0;

  phase_diff_avg #(.LOG2N(2)) dut (
    .clk(clk), .rst_n(rst_n), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_phase(sink_phase), .sink_clear(sink_clear), .source_valid(source_valid),
    .source_ready(source_ready), .source_freq(source_freq)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [15:0] ph);
    sink_valid = 1'b1;
    sink_phase = ph;
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
  endtask

  task automatic do_clear();
    sink_clear = 1'b1;
    @(posedge clk);
    #1;
    sink_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; sink_valid = 1'b0; sink_phase = 16'h0000; sink_clear = 1'b0; source_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (source_valid !== 1'b0 || source_freq !== 16'h0000 || sink_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: valid=%b freq=%h ready=%b, want 0 0000 1", source_valid, source_freq, sink_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (sink_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: ready=%b want 1", sink_ready);
    end
  endtask

  task automatic test_constant_step();
    for (int i = 0; i < 4; i++) begin
      send(16'(i * 256));
      vectors++;
      if (source_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL step_early[%0d]: valid=%b want 0", i, source_valid);
      end
    end
    send(16'h0400);
    vectors++;
    if (source_valid !== 1'b1 || source_freq !== 16'h0100) begin
      miscompares++;
      $display("FAIL step_result: valid=%b freq=%h want 1 0100", source_valid, source_freq);
    end
    @(posedge clk); #1;
    vectors++;
    if (source_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL step_pulse: valid=%b want 0", source_valid);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    send(16'h6000);
    send(16'h9B78); send(16'hA000); send(16'hA488);
    vectors++;
    if (source_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_early: valid=%b want 0", source_valid);
    end
    send(16'hA910);
    vectors++;
    if (source_valid !== 1'b1 || source_freq !== 16'h0488) begin
      miscompares++;
      $display("FAIL wrap_result: valid=%b freq=%h want 1 0488", source_valid, source_freq);
    end
  endtask

  task automatic test_neg_floor();
    do_clear();
    send(16'h0000); send(16'hFFFF); send(16'hFFFE); send(16'hFFFD); send(16'hFFFD);
    vectors++;
    if (source_valid !== 1'b1 || source_freq !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL neg_floor: valid=%b freq=%h want 1 ffff", source_valid, source_freq);
    end
  endtask

  task automatic test_pi_boundary();
    do_clear();
    send(16'h0000); send(16'h6488); send(16'h6488); send(16'h6488); send(16'h6488);
    vectors++;
    if (source_valid !== 1'b1 || source_freq !== 16'h1922) begin
      miscompares++;
      $display("FAIL plus_pi: valid=%b freq=%h want 1 1922", source_valid, source_freq);
    end
    // Reference 0x6488 carries over, so four samples suffice for the next result.
    send(16'h0000); send(16'h0000); send(16'h0000); send(16'h0000);
    vectors++;
    if (source_valid !== 1'b1 || source_freq !== 16'hE6DE) begin
      miscompares++;
      $display("FAIL minus_pi: valid=%b freq=%h want 1 e6de", source_valid, source_freq);
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    source_ready = 1'b0;
    send(16'h0000); send(16'h0010); send(16'h0020); send(16'h0030); send(16'h0040);
    for (int i = 0; i < 10; i++) begin
      sink_valid = 1'b1;
      sink_phase = 16'h7777;
      vectors++;
      if (sink_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: ready=%b want 0", i, sink_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (source_valid !== 1'b1 || source_freq !== 16'h0010) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b freq=%h want 1 0010", i, source_valid, source_freq);
      end
    end
    sink_valid = 1'b0;
    source_ready = 1'b1;
    #1;
    vectors++;
    if (sink_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: ready=%b want 1", sink_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (source_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_transfer: valid=%b want 0", source_valid);
    end
  endtask

  task automatic test_clear_same_cycle();
    do_clear();
    send(16'h5000); send(16'h5500);
    sink_clear = 1'b1;
    send(16'h2000);
    sink_clear = 1'b0;
    send(16'h2010); send(16'h2020); send(16'h2030);
    vectors++;
    if (source_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_early: valid=%b want 0", source_valid);
    end
    send(16'h2040);
    vectors++;
    if (source_valid !== 1'b1 || source_freq !== 16'h0010) begin
      miscompares++;
      $display("FAIL clr_result: valid=%b freq=%h want 1 0010", source_valid, source_freq);
    end
  endtask

  task automatic test_reset_mid_run();
    do_clear();
    send(16'h0000); send(16'h0700); send(16'h0E00);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (source_valid !== 1'b0 || source_freq !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b freq=%h want 0 0000", source_valid, source_freq);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(16'(16'h1000 + i * 256));
      vectors++;
      if (source_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_early[%0d]: valid=%b want 0", i, source_valid);
      end
    end
    send(16'h1400);
    vectors++;
    if (source_valid !== 1'b1 || source_freq !== 16'h0100) begin
      miscompares++;
      $display("FAIL rst_result: valid=%b freq=%h want 1 0100", source_valid, source_freq);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    send(16'h0000);
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 4; i++) begin
        send(16'((r * 4 + i) * 32));
        vectors++;
        if (source_valid !== (i == 4) || (i == 4 && source_freq !== 16'h0020)) begin
          miscompares++;
          $display("FAIL b2b[%0d.%0d]: valid=%b freq=%h want %b 0020", r, i, source_valid, source_freq, i == 4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant_step();
    test_wrap();
    test_neg_floor();
    test_pi_boundary();
    test_backpressure();
    test_clear_same_cycle();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
